mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port word memory between the core's instruction-fetch port and its load/store port. It accepts valid/ready requests from both sides, grants one access per cycle with round-robin on conflict, and merges byte-strobed stores against the memory's combinational read data. Each port gets a registered response one cycle after acceptance, held under back-pressure. It sits between the core and the memory block; the memory's `we`, `address`, `data_in` and `data_out` connect directly to the `mem_*` ports.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_rsp_slot.sv | 41 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   // Per byte lane: take new_word where the strobe is set, otherwise keep old_word.
   function automatic logic [DATA_W-1:0] merge_strb(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] merged;
      merged = old_word;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// Single-entry response register for one arbiter port.
// Latency: loaded response is visible one cycle after the accept edge.
// Backpressure: data/err hold while rsp_valid && !rsp_ready; reload and drain may coincide.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   load               an access on this port is accepted this cycle
//   load_data/err      response contents captured on load
//   rsp_ready          consumer takes the response this cycle
//   rsp_valid/data/err registered response towards the consumer
module mem_arb_rsp_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_err,
   input  logic              rsp_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   // The arbiter only loads when the slot is empty or draining, so a load
   // always wins over the clear without losing a response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_data  <= load_data;
         rsp_err   <= load_err;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational-read word memory between fetch and load/store.
// Latency: one access per cycle; response registered one cycle after accept.
// Backpressure: a port with an unconsumed response is not eligible; the other port takes every grant.
//
// Ports:
//   clk, resetn                               clock, asynchronous active-low reset
//   i_req_* / i_addr, i_rsp_*                 fetch request (read-only) and response
//   d_req_* / d_addr/we/wstrb/wdata, d_rsp_*  load/store request and response (stores return old word)
//   mem_addr/wdata/we, mem_rdata              direct connection to the memory
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,

   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [DATA_W-1:0]   i_rsp_data,
   output logic                i_rsp_err,

   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_rsp_valid,
   input  logic                d_rsp_ready,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                d_rsp_err,

   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_we,
   input  logic [DATA_W-1:0]   mem_rdata
);

   import mem_arb_pkg::*;

   logic   i_elig, d_elig;
   logic   gnt_i, gnt_d;
   logic   mis_i, mis_d;
   grant_t last_grant;

   // A port may issue only if its response slot is free or draining this cycle.
   assign i_elig = i_req_valid && (!i_rsp_valid || i_rsp_ready);
   assign d_elig = d_req_valid && (!d_rsp_valid || d_rsp_ready);

   assign mis_i = (i_addr[1:0] != 2'b00);
   assign mis_d = (d_addr[1:0] != 2'b00);

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (i_elig && d_elig) begin
         if (last_grant == GRANT_D) begin
            gnt_i = 1'b1;
         end else begin
            gnt_d = 1'b1;
         end
      end else if (i_elig) begin
         gnt_i = 1'b1;
      end else if (d_elig) begin
         gnt_d = 1'b1;
      end
   end

   assign i_req_ready = gnt_i;
   assign d_req_ready = gnt_d;

   // Store data is merged against the current word so partial-strobe writes
   // become a single full-word write on the accept edge.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (gnt_i) begin
         mem_addr  = i_addr;
         mem_wdata = merge_strb(mem_rdata, d_wdata, d_wstrb);
      end else if (gnt_d) begin
         mem_addr  = d_addr;
         mem_wdata = merge_strb(mem_rdata, d_wdata, d_wstrb);
         // resetn gating keeps the memory untouched while the block is held in reset.
         mem_we    = d_we && (|d_wstrb) && !mis_d && resetn;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant <= GRANT_D;
      end else if (gnt_i) begin
         last_grant <= GRANT_I;
      end else if (gnt_d) begin
         last_grant <= GRANT_D;
      end
   end

   mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_i_slot (
      .clk       (clk),
      .resetn    (resetn),
      .load      (gnt_i),
      .load_data (mis_i ? '0 : mem_rdata),
      .load_err  (mis_i),
      .rsp_ready (i_rsp_ready),
      .rsp_valid (i_rsp_valid),
      .rsp_data  (i_rsp_data),
      .rsp_err   (i_rsp_err)
   );

   mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_d_slot (
      .clk       (clk),
      .resetn    (resetn),
      .load      (gnt_d),
      .load_data (mis_d ? '0 : mem_rdata),
      .load_err  (mis_d),
      .rsp_ready (d_rsp_ready),
      .rsp_valid (d_rsp_valid),
      .rsp_data  (d_rsp_data),
      .rsp_err   (d_rsp_err)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory.
// Latency: n/a.
// Backpressure: exercised through explicit rsp_ready sequences.
module tb_mem_arbiter;

   logic        clk;
   logic        resetn;
   logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
   logic [31:0] i_addr, i_rsp_data;
   logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr, d_wdata, d_rsp_data;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_req_valid (i_req_valid),
      .i_req_ready (i_req_ready),
      .i_addr      (i_addr),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .i_rsp_data  (i_rsp_data),
      .i_rsp_err   (i_rsp_err),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready),
      .d_addr      (d_addr),
      .d_we        (d_we),
      .d_wstrb     (d_wstrb),
      .d_wdata     (d_wdata),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_ready (d_rsp_ready),
      .d_rsp_data  (d_rsp_data),
      .d_rsp_err   (d_rsp_err),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
   end

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + 32'(k);
      mem[4] = 32'hCAFE_F00D;
      mem[8] = 32'h1122_3344;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                        input logic [31:0] da, input logic dwe, input logic [3:0] ds,
                        input logic [31:0] dd);
      i_req_valid = iv;
      i_addr      = ia;
      d_req_valid = dv;
      d_addr      = da;
      d_we        = dwe;
      d_wstrb     = ds;
      d_wdata     = dd;
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic        dwe;
      logic [3:0]  ds;
      logic [31:0] dd;
      logic        e_ir, e_dr, e_we;
      logic        e_iv;
      logic [31:0] e_id;
      logic        e_ie;
      logic        e_dv;
      logic [31:0] e_dd;
      logic        e_de;
   } vec_t;

   vec_t vt [12];
   int   i_acc, d_acc;
   logic [31:0] held;

   initial begin
      //          iv    ia          dv    da          we    s     dd            ir    dr    we    iv    id            ie    dv    dd            de
      vt[0]  = '{1'b1, 32'h10, 1'b0, 32'h00, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,         1'b0};
      vt[1]  = '{1'b1, 32'h14, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hA000_0009, 1'b0};
      vt[2]  = '{1'b1, 32'h14, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hA000_0005, 1'b0, 1'b0, 32'hA000_0009, 1'b0};
      vt[3]  = '{1'b1, 32'h14, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'hA000_0009, 1'b0};
      vt[4]  = '{1'b0, 32'h00, 1'b1, 32'h20, 1'b1, 4'h5, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'h1122_3344, 1'b0};
      vt[5]  = '{1'b0, 32'h00, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'h11BB_33DD, 1'b0};
      vt[6]  = '{1'b0, 32'h00, 1'b1, 32'h22, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'h0,         1'b1};
      vt[7]  = '{1'b0, 32'h00, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'h11BB_33DD, 1'b0};
      vt[8]  = '{1'b0, 32'h00, 1'b1, 32'h24, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'hA000_0009, 1'b0};
      vt[9]  = '{1'b0, 32'h00, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 32'hA000_0009, 1'b0};
      vt[10] = '{1'b1, 32'h11, 1'b0, 32'h00, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'hA000_0009, 1'b0};
      vt[11] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA000_0009, 1'b0};

      resetn      = 1'b0;
      i_rsp_ready = 1'b1;
      d_rsp_ready = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
      chk("rst_i_rsp_data",  i_rsp_data,       32'd0);
      chk("rst_i_rsp_err",   32'(i_rsp_err),   32'd0);
      chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
      chk("rst_d_rsp_data",  d_rsp_data,       32'd0);
      chk("rst_d_rsp_err",   32'(d_rsp_err),   32'd0);
      chk("rst_mem_we",      32'(mem_we),      32'd0);
      chk("rst_mem_addr",    mem_addr,         32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven vectors
      for (int v = 0; v < 12; v++) begin
         @(negedge clk);
         drive(vt[v].iv, vt[v].ia, vt[v].dv, vt[v].da, vt[v].dwe, vt[v].ds, vt[v].dd);
         #1;
         chk($sformatf("v%0d_i_req_ready", v), 32'(i_req_ready), 32'(vt[v].e_ir));
         chk($sformatf("v%0d_d_req_ready", v), 32'(d_req_ready), 32'(vt[v].e_dr));
         chk($sformatf("v%0d_mem_we", v),      32'(mem_we),      32'(vt[v].e_we));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_i_rsp_valid", v), 32'(i_rsp_valid), 32'(vt[v].e_iv));
         chk($sformatf("v%0d_i_rsp_data", v),  i_rsp_data,       vt[v].e_id);
         chk($sformatf("v%0d_i_rsp_err", v),   32'(i_rsp_err),   32'(vt[v].e_ie));
         chk($sformatf("v%0d_d_rsp_valid", v), 32'(d_rsp_valid), 32'(vt[v].e_dv));
         chk($sformatf("v%0d_d_rsp_data", v),  d_rsp_data,       vt[v].e_dd);
         chk($sformatf("v%0d_d_rsp_err", v),   32'(d_rsp_err),   32'(vt[v].e_de));
      end
      chk("mem_0x20_after_merge", mem[8], 32'h11BB_33DD);
      chk("mem_0x24_after_zero_strb", mem[9], 32'hA000_0009);

      // Round-robin alternation from reset: I, D, I, D ...
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      drive(1'b1, 32'h10, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
      i_acc = 0;
      d_acc = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("rr%0d_i_req_ready", c), 32'(i_req_ready), 32'((c % 2) == 0));
         chk($sformatf("rr%0d_d_req_ready", c), 32'(d_req_ready), 32'((c % 2) == 1));
         if (i_req_ready) i_acc++;
         if (d_req_ready) d_acc++;
         @(negedge clk);
      end
      chk("rr_i_accepts", 32'(i_acc), 32'd4);
      chk("rr_d_accepts", 32'(d_acc), 32'd4);

      // Data response back-pressure: D load, then hold d_rsp_ready low for 3 cycles
      drive(1'b0, 32'h0, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("bp_load_valid", 32'(d_rsp_valid), 32'd1);
      chk("bp_load_data",  d_rsp_data,       32'hA000_0009);
      @(negedge clk);
      d_rsp_ready = 1'b0;
      drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
      held = d_rsp_data;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_d_req_ready", c), 32'(d_req_ready), 32'd0);
         chk($sformatf("bp%0d_i_req_ready", c), 32'(i_req_ready), 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_d_rsp_valid", c), 32'(d_rsp_valid), 32'd1);
         chk($sformatf("bp%0d_d_rsp_data", c),  d_rsp_data,       held);
         chk($sformatf("bp%0d_i_rsp_data", c),  i_rsp_data,       32'hCAFE_F00D);
         @(negedge clk);
      end
      d_rsp_ready = 1'b1;
      #1;
      chk("bp_release_d_req_ready", 32'(d_req_ready), 32'd1);
      chk("bp_release_i_req_ready", 32'(i_req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_release_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("bp_release_d_rsp_data",  d_rsp_data,       32'h11BB_33DD);

      // Asynchronous reset with a pending fetch response
      @(negedge clk);
      i_rsp_ready = 1'b0;
      drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("ar_pending_valid", 32'(i_rsp_valid), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 32'h30, 1'b1, 4'hF, 32'h1234_5678);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_i_rsp_valid_dropped", 32'(i_rsp_valid), 32'd0);
      chk("ar_i_rsp_data_cleared",  i_rsp_data,       32'd0);
      chk("ar_mem_we_in_reset",     32'(mem_we),      32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("ar_mem_unchanged", mem[12], 32'hA000_000C);
      resetn = 1'b1;
      i_rsp_ready = 1'b1;
      drive(1'b1, 32'h10, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
      #1;
      chk("ar_first_conflict_i", 32'(i_req_ready), 32'd1);
      chk("ar_first_conflict_d", 32'(d_req_ready), 32'd0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
